// File: rtl/fetch_unit_if.sv
// Program ROM bus between the fetch unit and the instruction memory.
// The fetch unit is the master: it drives the address and read strobe.
interface fetch_unit_if #(
    parameter int PC_W = 8
);
    logic [PC_W-1:0] imemAddr;
    logic            imemRd;
    logic [11:0]     imemData;

    modport master (
        output imemAddr,
        output imemRd,
        input  imemData
    );

    modport slave (
        input  imemAddr,
        input  imemRd,
        output imemData
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: FETCH/LOAD/EXEC per instruction,
// local resolution of unconditional jump and halt.
module fetch_unit #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    fetch_unit_if.master       imem,
    output logic [3:0]         opCode,
    output logic [7:0]         operand,
    output logic               instrValid,
    output logic [PC_W-1:0]    pc,
    output logic               halted
);

    localparam logic [3:0] OP_JMP = 4'b1011;
    localparam logic [3:0] OP_HLT = 4'b1111;
    localparam logic [3:0] OP_NOP = 4'b1100;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        EXEC,
        HALT
    } state_t;

    state_t      state;
    logic [11:0] ir;
    logic        rd;

    assign imem.imemAddr = pc;
    assign imem.imemRd   = rd;
    assign operand       = ir[7:0];

    // Sequencer with registered strobe, valid and opcode outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            ir         <= 12'hC00;
            halted     <= 1'b0;
            rd         <= 1'b0;
            instrValid <= 1'b0;
            opCode     <= OP_NOP;
        end else begin
            unique case (state)
                IDLE: begin
                    state <= FETCH;
                    rd    <= 1'b1;
                end
                FETCH: begin
                    state <= LOAD;
                    rd    <= 1'b0;
                end
                LOAD: begin
                    ir         <= imem.imemData;
                    opCode     <= imem.imemData[11:8];
                    instrValid <= 1'b1;
                    state      <= EXEC;
                end
                EXEC: begin
                    if (!stall) begin
                        instrValid <= 1'b0;
                        opCode     <= OP_NOP;
                        if (ir[11:8] == OP_HLT) begin
                            halted <= 1'b1;
                            state  <= HALT;
                        end else begin
                            if (ir[11:8] == OP_JMP) begin
                                pc <= PC_W'(ir[7:0]);
                            end else begin
                                pc <= pc + PC_W'(1);
                            end
                            rd    <= 1'b1;
                            state <= FETCH;
                        end
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch sequencer for the 8-bit CPU. It holds the program counter, reads 12-bit instruction words from a synchronous program ROM, and presents the 4-bit opcode to the control unit one instruction at a time. It resolves unconditional jumps (opcode 4'b1011) and halt (opcode 4'b1111) locally. It sits directly upstream of the control unit and drives that unit's opCode input.

## Interface

Parameters:
- PC_W, 8, program counter and ROM address width.
- RESET_PC, 0, PC value loaded on reset.

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  hold the current instruction in EXEC.
- imemAddr  output  PC_W  program ROM address; equals pc.
- imemRd  output  1  ROM read strobe.
- imemData  input  12  ROM read data, valid the cycle after imemRd; [11:8] opcode, [7:0] operand.
- opCode  output  4  opcode to the control unit; 4'b1100 (NOP) when instrValid=0.
- operand  output  8  operand of the current instruction (IR[7:0]).
- instrValid  output  1  opCode/operand hold a live instruction.
- pc  output  PC_W  address of the instruction currently fetched or issued.
- halted  output  1  sticky halt indicator.

## Operation

- Registers: pc[PC_W-1:0], ir[11:0], state (IDLE, FETCH, LOAD, EXEC, HALT), halted.
- All outputs decode from registered state (Moore outputs); there are no combinational input-to-output paths.
- Reset values: state=IDLE, pc=RESET_PC, ir=12'hC00, halted=0, imemRd=0, instrValid=0, opCode=4'b1100, operand=0.
- IDLE: all outputs idle. Next state is FETCH.
- FETCH: imemRd=1, imemAddr=pc. Next state is LOAD.
- LOAD: imemRd=0. ir<=imemData at the end of the cycle. Next state is EXEC.
- EXEC: instrValid=1, opCode=ir[11:8], operand=ir[7:0].
  - stall=1: stay in EXEC. Outputs are held stable and pc is unchanged.
  - stall=0, opcode 4'b1011: pc<=ir[PC_W-1:0]; operand is zero-extended if PC_W>8. Next state is FETCH.
  - stall=0, opcode 4'b1111: pc is unchanged; halted<=1. Next state is HALT.
  - stall=0, any other opcode: pc<=pc+1, modulo 2^PC_W (so 8'hFF wraps to 8'h00). Next state is FETCH.
- HALT: imemRd=0, instrValid=0, opCode=NOP, halted=1. Only rst leaves this state.
- stall is ignored in IDLE, FETCH, LOAD and HALT.
- rst has priority over every transition in every state, including mid-fetch, stalled EXEC and HALT.
- The 12'hC00 NOP maps to the control unit's default case, so no write enables assert while no instruction is live.

## Timing

- Cycle k means k rising edges after the edge that samples rst=0.
  - Cycle 0: IDLE.
  - Cycle 1: FETCH, imemAddr=RESET_PC.
  - Cycle 2: LOAD.
  - Cycle 3: EXEC, first instrValid=1.
- Unstalled throughput is one instruction per 3 cycles (FETCH, LOAD, EXEC). instrValid is a single-cycle pulse per instruction.
- With s stall cycles, EXEC lasts 1+s cycles. FETCH of the next instruction occurs the cycle after the first EXEC cycle sampled with stall=0.
- A taken jump adds no penalty: the FETCH after the jump uses the target address.
- halted rises the cycle after the halt EXEC cycle. instrValid is high for exactly one cycle with opCode=4'b1111.
- ROM latency is fixed at 1 cycle. imemData is sampled only at the end of LOAD.

## Test plan

- Sequential fetch: ROM[0]=12'h205, ROM[1]=12'h307, ROM[2]=12'h000, release rst -> imemRd pulses at cycles 1, 4, 7 with imemAddr 0, 1, 2; instrValid at cycles 3, 6, 9 with opCode 2, 3, 0 and operand 05, 07, 00; opCode=4'hC in all other cycles.
- Jump: ROM[3]=12'hB10, ROM[16]=12'h401 -> the FETCH after the jump EXEC has imemAddr=8'h10; the next issued opCode is 4, operand 01, pc 8'h10.
- Wrap: RESET_PC=8'hFF, ROM[FF]=12'h000 -> the second FETCH has imemAddr=8'h00.
- Stall: stall=1 for 4 cycles starting at the first EXEC cycle -> instrValid, opCode and pc stable for 5 cycles; imemRd=1 exactly one cycle after stall drops; pc advances by 1.
- Halt: ROM[2]=12'hF00 -> one instrValid cycle with opCode F, then halted=1, imemRd=0 and opCode=4'hC held for 20+ cycles with stall toggling; pulsing rst clears halted and restarts the fetch at RESET_PC.
- Reset mid-operation: assert rst during LOAD, then during a stalled EXEC -> the next cycle shows IDLE outputs (instrValid=0, imemRd=0, pc=RESET_PC), and the fetch restarts with the cycle 1/2/3 timing.
